// File: rtl/count_day.sv
// Day-of-month counter (BCD 01..31) for the century clock. Advances on the daily
// carry, clamps to the current month length and emits the month-advance pulse.
module count_day #(
  parameter int MAX_DISPLAY_UNIT = 4,
  parameter int MAX_DISPLAY_TEN  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_dy,
  input  logic                        set_mode,
  input  logic                        up,
  input  logic                        down,
  input  logic                        T,
  input  logic                        TO,
  input  logic                        TN,
  input  logic                        leap,
  output logic [MAX_DISPLAY_UNIT-1:0] day_unit,
  output logic [MAX_DISPLAY_TEN-1:0]  day_ten,
  output logic                        pulse_dy
);

  logic [MAX_DISPLAY_UNIT-1:0] r_unit;
  logic [MAX_DISPLAY_TEN-1:0]  r_ten;
  logic [MAX_DISPLAY_UNIT-1:0] w_nextUnit;
  logic [MAX_DISPLAY_TEN-1:0]  w_nextTen;
  logic [MAX_DISPLAY_UNIT-1:0] w_lenUnit;
  logic [MAX_DISPLAY_TEN-1:0]  w_lenTen;
  logic [MAX_DISPLAY_UNIT-1:0] w_incUnit;
  logic [MAX_DISPLAY_TEN-1:0]  w_incTen;
  logic [MAX_DISPLAY_UNIT-1:0] w_decUnit;
  logic [MAX_DISPLAY_TEN-1:0]  w_decTen;
  logic                        w_tenBad;
  logic                        w_valid;
  logic                        w_atMax;
  logic                        w_overLen;

  // Anything other than a clean one-hot month class is treated as a 31-day month.
  always_comb begin
    w_lenTen  = MAX_DISPLAY_TEN'(3);
    w_lenUnit = MAX_DISPLAY_UNIT'(1);
    unique case ({T, TO, TN})
      3'b010:  w_lenUnit = MAX_DISPLAY_UNIT'(0);
      3'b001: begin
        w_lenTen  = MAX_DISPLAY_TEN'(2);
        w_lenUnit = leap ? MAX_DISPLAY_UNIT'(9) : MAX_DISPLAY_UNIT'(8);
      end
      default: ;
    endcase
  end

  generate
    if (MAX_DISPLAY_TEN > 2) begin : g_tenCheck
      assign w_tenBad = (r_ten > MAX_DISPLAY_TEN'(3));
    end else begin : g_tenNoCheck
      assign w_tenBad = 1'b0;
    end
  endgenerate

  assign w_valid   = (r_unit <= MAX_DISPLAY_UNIT'(9)) && !w_tenBad &&
                     !((r_unit == '0) && (r_ten == '0));
  assign w_atMax   = (r_ten == w_lenTen) && (r_unit == w_lenUnit);
  assign w_overLen = (r_ten > w_lenTen) || ((r_ten == w_lenTen) && (r_unit > w_lenUnit));

  assign w_incUnit = (r_unit == MAX_DISPLAY_UNIT'(9)) ? '0 : r_unit + MAX_DISPLAY_UNIT'(1);
  assign w_incTen  = (r_unit == MAX_DISPLAY_UNIT'(9)) ? r_ten + MAX_DISPLAY_TEN'(1) : r_ten;
  assign w_decUnit = (r_unit == '0) ? MAX_DISPLAY_UNIT'(9) : r_unit - MAX_DISPLAY_UNIT'(1);
  assign w_decTen  = (r_unit == '0) ? r_ten - MAX_DISPLAY_TEN'(1) : r_ten;

  // Repair and clamp take precedence over setting and advancing.
  always_comb begin
    w_nextUnit = r_unit;
    w_nextTen  = r_ten;
    if (!w_valid) begin
      w_nextUnit = MAX_DISPLAY_UNIT'(1);
      w_nextTen  = '0;
    end else if (w_overLen) begin
      w_nextUnit = w_lenUnit;
      w_nextTen  = w_lenTen;
    end else if (set_mode) begin
      if (up && !down) begin
        if (w_atMax) begin
          w_nextUnit = MAX_DISPLAY_UNIT'(1);
          w_nextTen  = '0;
        end else begin
          w_nextUnit = w_incUnit;
          w_nextTen  = w_incTen;
        end
      end else if (down && !up) begin
        if ((r_ten == '0) && (r_unit == MAX_DISPLAY_UNIT'(1))) begin
          w_nextUnit = w_lenUnit;
          w_nextTen  = w_lenTen;
        end else begin
          w_nextUnit = w_decUnit;
          w_nextTen  = w_decTen;
        end
      end
    end else if (en_dy) begin
      if (w_atMax) begin
        w_nextUnit = MAX_DISPLAY_UNIT'(1);
        w_nextTen  = '0;
      end else begin
        w_nextUnit = w_incUnit;
        w_nextTen  = w_incTen;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_unit <= MAX_DISPLAY_UNIT'(1);
      r_ten  <= '0;
    end else begin
      r_unit <= w_nextUnit;
      r_ten  <= w_nextTen;
    end
  end

  assign day_unit = r_unit;
  assign day_ten  = r_ten;
  assign pulse_dy = en_dy && !set_mode && w_atMax && w_valid && !w_overLen;

endmodule
